muu_tenant_rr_arbiter: RTL

- Shares the single request-splitter input among 2**USER_BITS per-tenant request streams.
- Packet-granular round-robin arbiter: locks a grant for a whole tlast-terminated packet, forwards it beat-by-beat, and tags it with the winning tenant id on m_axis_tuserid.
- Sits between per-tenant network ingress FIFOs and the request splitter.

---
 rtl/muu_tenant_rr_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/muu_tenant_rr_arbiter.sv
// rtl/muu_tenant_rr_arbiter.sv - packet-granular round-robin arbiter across tenant request streams
// Optional per-tenant packet counters when MUU_ARB_STATS_EN is defined.
module muu_tenant_rr_arbiter #(
    parameter int USER_BITS  = 3,
    parameter int DATA_WIDTH = 576
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [(2**USER_BITS)*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [(2**USER_BITS)-1:0]             s_axis_tvalid,
    input  logic [(2**USER_BITS)-1:0]             s_axis_tlast,
    output logic [(2**USER_BITS)-1:0]             s_axis_tready,
    output logic [DATA_WIDTH-1:0]                 m_axis_tdata,
    output logic                                  m_axis_tvalid,
    output logic                                  m_axis_tlast,
    output logic [USER_BITS-1:0]                  m_axis_tuserid,
    input  logic                                  m_axis_tready,
    input  logic [(2**USER_BITS)-1:0]             user_enable,
    output logic [USER_BITS-1:0]                  grant_id,
    output logic                                  busy
`ifdef MUU_ARB_STATS_EN
    ,
    output logic [(2**USER_BITS)*32-1:0]          pkt_count
`endif
);

    localparam int NUM_USERS = 2**USER_BITS;

    typedef enum logic {
        ST_IDLE,
        ST_FWD
    } state_t;

    state_t                 state_q, state_d;
    logic [USER_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic [USER_BITS-1:0]   grant_id_q, grant_id_d;

    logic [NUM_USERS-1:0]   req;
    logic [USER_BITS-1:0]   idx;
    logic [USER_BITS-1:0]   pick;
    logic                   pick_vld;
    logic                   fwd;
    logic                   pkt_done;

    // Scan from farthest to nearest so the last hit is the first set bit at/after rr_ptr.
    always_comb begin
        req      = s_axis_tvalid & user_enable;
        idx      = '0;
        pick     = rr_ptr_q;
        pick_vld = 1'b0;
        for (int k = NUM_USERS - 1; k >= 0; k--) begin
            idx = rr_ptr_q + USER_BITS'(k);
            if (req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        fwd            = (state_q == ST_FWD);
        m_axis_tdata   = s_axis_tdata[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tvalid  = fwd & s_axis_tvalid[grant_id_q];
        m_axis_tlast   = fwd & s_axis_tlast[grant_id_q];
        m_axis_tuserid = grant_id_q;
        s_axis_tready  = '0;
        if (fwd) begin
            s_axis_tready[grant_id_q] = m_axis_tready;
        end
        pkt_done       = m_axis_tvalid & m_axis_tready & m_axis_tlast;
        grant_id       = grant_id_q;
        busy           = fwd;
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_id_d = pick;
                    state_d    = ST_FWD;
                end
            end
            ST_FWD: begin
                if (pkt_done) begin
                    rr_ptr_d = grant_id_q + 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
        end
    end

`ifdef MUU_ARB_STATS_EN
    logic [31:0] pkt_count_q [NUM_USERS];
    logic [31:0] pkt_count_d [NUM_USERS];

    always_comb begin
        for (int i = 0; i < NUM_USERS; i++) begin
            pkt_count_d[i] = pkt_count_q[i];
        end
        if (pkt_done) begin
            pkt_count_d[grant_id_q] = pkt_count_q[grant_id_q] + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_USERS; i++) begin
                pkt_count_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_USERS; i++) begin
                pkt_count_q[i] <= pkt_count_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_USERS; g++) begin : g_cnt
        assign pkt_count[g*32 +: 32] = pkt_count_q[g];
    end
`endif

endmodule
